// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [3:0]        m0_be;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [3:0]        m1_be;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_be
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the core (m0) and a
// debug loader (m1), with a bounded m1 burst lock so m0 cannot starve.
module mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  localparam logic [7:0] MAX_C = 8'(MAX_LOCK);

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic        gnt0, gnt1;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_we_d;
  logic [3:0]        mem_be_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  // A lock that drops (or whose request drops) falls straight through to the
  // IDLE rules in the same cycle, so no dead cycle is inserted.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    if (state_q == LOCK1 && bus.m1_req && bus.m1_lock) begin
      if (lock_cnt_q == MAX_C && bus.m0_req) begin
        gnt0       = 1'b1;
        state_d    = IDLE;
        last_gnt_d = 1'b0;
        lock_cnt_d = '0;
      end else begin
        gnt1 = 1'b1;
        if (lock_cnt_q != MAX_C) lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
      if (bus.m0_req && bus.m1_req) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
      if (gnt0) last_gnt_d = 1'b0;
      if (gnt1) begin
        last_gnt_d = 1'b1;
        if (bus.m1_lock) begin
          state_d    = LOCK1;
          lock_cnt_d = 8'd1;
        end
      end
    end

    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    rv0_d = gnt0 & ~bus.m0_we;
    rv1_d = gnt1 & ~bus.m1_we;
  end

  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    if (gnt0) begin
      mem_addr_d  = bus.m0_addr;
      mem_wdata_d = bus.m0_wdata;
      mem_we_d    = bus.m0_we;
      mem_be_d    = bus.m0_be;
    end else if (gnt1) begin
      mem_addr_d  = bus.m1_addr;
      mem_wdata_d = bus.m1_wdata;
      mem_we_d    = bus.m1_we;
      mem_be_d    = bus.m1_be;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_be    = mem_be_d;

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0_q & ~rst;
  assign bus.m1_rvalid = rv1_q & ~rst;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reads push expected data when granted,
// a negedge monitor pops and compares when rvalid is due.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_rdata <= mem_model(bus.mem_addr);
  end

  always @(negedge clk) begin
    checks++;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== q0[0].data) begin
        errors++;
        $display("FAIL m0_read cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                 cyc, bus.m0_rvalid, bus.m0_rdata, q0[0].data);
      end
      void'(q0.pop_front());
    end else if (bus.m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL m0_spurious_rvalid cyc=%0d got %b want 0", cyc, bus.m0_rvalid);
    end
    checks++;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== q1[0].data) begin
        errors++;
        $display("FAIL m1_read cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                 cyc, bus.m1_rvalid, bus.m1_rdata, q1[0].data);
      end
      void'(q1.pop_front());
    end else if (bus.m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL m1_spurious_rvalid cyc=%0d got %b want 0", cyc, bus.m1_rvalid);
    end
  end

  task automatic drive0(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_be = be;
    bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    bus.m1_req = req; bus.m1_we = we; bus.m1_be = be;
    bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_lock = lock;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_all();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic push_rd(input int m, input logic [31:0] addr);
    exp_t e;
    e.due  = cyc + 1;
    e.data = mem_model(addr);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_be} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctrl phase=%0d got gnt0=%b gnt1=%b we=%b be=%b want all 0",
                 i, bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_be);
      end
      checks++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_bus phase=%0d got addr=%h wdata=%h want 0", i, bus.mem_addr, bus.mem_wdata);
      end
      next_cycle();
      rst = 1'b0;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    drive0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt got gnt0=%b gnt1=%b want 1 0", bus.m0_gnt, bus.m1_gnt);
    end
    checks++;
    if (bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
      errors++;
      $display("FAIL single_bus got addr=%h we=%b be=%h want 10 0 f", bus.mem_addr, bus.mem_we, bus.mem_be);
    end
    push_rd(0, 32'h10);
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rdata got %h want deadbeef", bus.m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    logic [31:0] a0, a1;
    logic exp0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a0 = 32'h100 + 32'(n0 * 4);
      a1 = 32'h200 + 32'(n1 * 4);
      drive0(1'b1, 1'b0, 4'hF, a0, 32'h0);
      drive1(1'b1, 1'b0, 4'hF, a1, 32'h0, 1'b0);
      exp0 = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (bus.m0_gnt !== exp0 || bus.m1_gnt !== ~exp0) begin
        errors++;
        $display("FAIL rr_gnt i=%0d got gnt0=%b gnt1=%b want %b %b", i, bus.m0_gnt, bus.m1_gnt, exp0, ~exp0);
      end
      checks++;
      if (bus.mem_addr !== (exp0 ? a0 : a1)) begin
        errors++;
        $display("FAIL rr_addr i=%0d got %h want %h", i, bus.mem_addr, exp0 ? a0 : a1);
      end
      if (exp0) begin push_rd(0, a0); n0++; end
      else      begin push_rd(1, a1); n1++; end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_lock_write();
    drive1(1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
        errors++;
        $display("FAIL lockw_gnt i=%0d got gnt1=%b gnt0=%b want 1 0", i, bus.m1_gnt, bus.m0_gnt);
      end
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011 ||
          bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h1234) begin
        errors++;
        $display("FAIL lockw_bus i=%0d got we=%b be=%b addr=%h wdata=%h want 1 0011 20 1234",
                 i, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_max_lock();
    logic [31:0] a0;
    logic exp0;
    drive0(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL maxlock_pre got gnt0=%b want 1", bus.m0_gnt);
    end
    push_rd(0, 32'h40);
    next_cycle();
    a0 = 32'h44;
    drive0(1'b1, 1'b0, 4'hF, a0, 32'h0);
    drive1(1'b1, 1'b1, 4'hF, 32'h80, 32'h55, 1'b1);
    for (int i = 0; i < 10; i++) begin
      exp0 = (i % 5 == 4);
      @(negedge clk);
      checks++;
      if (bus.m0_gnt !== exp0 || bus.m1_gnt !== ~exp0) begin
        errors++;
        $display("FAIL maxlock_gnt i=%0d got gnt0=%b gnt1=%b want %b %b", i, bus.m0_gnt, bus.m1_gnt, exp0, ~exp0);
      end
      if (exp0) push_rd(0, a0);
      next_cycle();
      if (exp0) begin
        a0 = a0 + 32'h4;
        drive0(1'b1, 1'b0, 4'hF, a0, 32'h0);
      end
    end
    drain();
  endtask

  task automatic test_lock_release();
    logic exp0;
    drive1(1'b1, 1'b1, 4'hF, 32'h90, 32'h1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rel_enter got gnt1=%b want 1", bus.m1_gnt);
    end
    next_cycle();
    drive0(1'b1, 1'b0, 4'hF, 32'h60, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rel_hold got gnt1=%b gnt0=%b want 1 0", bus.m1_gnt, bus.m0_gnt);
    end
    next_cycle();
    bus.m1_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || bus.mem_addr !== 32'h60) begin
      errors++;
      $display("FAIL rel_same_cycle got gnt0=%b gnt1=%b addr=%h want 1 0 60", bus.m0_gnt, bus.m1_gnt, bus.mem_addr);
    end
    push_rd(0, 32'h60);
    next_cycle();
    drive0(1'b1, 1'b0, 4'hF, 32'h64, 32'h0);
    bus.m1_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp0 = (i == 4);
      @(negedge clk);
      checks++;
      if (bus.m0_gnt !== exp0 || bus.m1_gnt !== ~exp0) begin
        errors++;
        $display("FAIL rel_reburst i=%0d got gnt0=%b gnt1=%b want %b %b", i, bus.m0_gnt, bus.m1_gnt, exp0, ~exp0);
      end
      if (exp0) push_rd(0, 32'h64);
      next_cycle();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    drive1(1'b1, 1'b0, 4'hF, 32'h70, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstf_grant got gnt1=%b want 1", bus.m1_gnt);
    end
    next_cycle();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.m1_rvalid !== 1'b0 || bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstf_quiet got rvalid1=%b gnt0=%b gnt1=%b want 0 0 0", bus.m1_rvalid, bus.m0_gnt, bus.m1_gnt);
    end
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rstf_bus got we=%b be=%h addr=%h wdata=%h want 0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 4'hF, 32'hA0, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 32'hB0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstf_contend got gnt0=%b gnt1=%b want 1 0", bus.m0_gnt, bus.m1_gnt);
    end
    push_rd(0, 32'hA0);
    next_cycle();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_write();
    test_max_lock();
    test_lock_release();
    test_reset_inflight();
    next_cycle();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
